// File: rtl/mem_control_unit_if.sv
// Datapath-side bundle of the memory-instruction control sequencer:
// the IR and memory handshake it consumes and the strobes it drives.
interface mem_control_unit_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        MARin;
    logic        Zin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        IncPC;
    logic        Read;
    logic        ReadEn;
    logic        Write;
    logic        Gra;
    logic        Grb;
    logic        Rin;
    logic        Rout;
    logic        BAout;
    logic        Cout;
    logic        ADD;

    // Control unit side: drives strobes, observes IR and memory ready.
    modport master (
        input  IR, Mem_ready,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ReadEn, Write, Gra, Grb, Rin, Rout, BAout,
               Cout, ADD
    );

    // Datapath side: consumes strobes, supplies IR and memory ready.
    modport slave (
        output IR, Mem_ready,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, ReadEn, Write, Gra, Grb, Rin, Rout, BAout,
               Cout, ADD
    );
endinterface

// File: rtl/mem_control_unit.sv
// Hardwired control sequencer for ld / ldi / st: fetch, effective-address
// formation and per-instruction tail, with memory-ready wait states and
// start / stop / halt handling.
module mem_control_unit (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Start,
    input  logic                 Stop,
    output logic                 Run,
    output logic                 Illegal,
    output logic [15:0]          Instr_count,
    mem_control_unit_if.master   bus
);

    // T5-T7 are split per instruction; the split taken at the end of T4
    // is what captures the opcode, so later IR changes are ignored.
    typedef enum logic [3:0] {
        S_HALT,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5_LD,
        S_T5_LDI,
        S_T5_ST,
        S_T6_LD,
        S_T6_ST,
        S_T7_LD,
        S_T7_ST
    } state_t;

    typedef struct packed {
        logic run;
        logic pcout;
        logic zlowout;
        logic mdrout;
        logic marin;
        logic zin;
        logic pcin;
        logic mdrin;
        logic irin;
        logic yin;
        logic incpc;
        logic read;
        logic readen;
        logic write;
        logic gra;
        logic grb;
        logic rin;
        logic rout;
        logic baout;
        logic cout;
        logic add;
    } strobes_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      r_state;
    state_t      w_next_state;
    strobes_t    r_out;
    logic        r_illegal;
    logic [15:0] r_count;
    logic        w_retire;
    logic        w_bad_op;
    logic [4:0]  w_opcode;
    logic        w_unused_ir;

    assign w_opcode    = bus.IR[31:27];
    assign w_unused_ir = ^bus.IR[26:0];

    // Moore strobe pattern for each state.
    function automatic strobes_t f_decode(input state_t s);
        strobes_t o;
        o     = '0;
        o.run = (s != S_HALT);
        case (s)
            S_T0: begin
                o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin = 1'b1;
            end
            S_T1: begin
                o.zlowout = 1'b1; o.pcin = 1'b1; o.read = 1'b1;
                o.readen  = 1'b1; o.mdrin = 1'b1;
            end
            S_T2: begin
                o.mdrout = 1'b1; o.irin = 1'b1;
            end
            S_T3: begin
                o.grb = 1'b1; o.baout = 1'b1; o.yin = 1'b1;
            end
            S_T4: begin
                o.cout = 1'b1; o.add = 1'b1; o.zin = 1'b1;
            end
            S_T5_LD, S_T5_ST: begin
                o.zlowout = 1'b1; o.marin = 1'b1;
            end
            S_T5_LDI: begin
                o.zlowout = 1'b1; o.gra = 1'b1; o.rin = 1'b1;
            end
            S_T6_LD: begin
                o.read = 1'b1; o.readen = 1'b1; o.mdrin = 1'b1;
            end
            S_T6_ST: begin
                o.gra = 1'b1; o.rout = 1'b1; o.mdrin = 1'b1;
            end
            S_T7_LD: begin
                o.mdrout = 1'b1; o.gra = 1'b1; o.rin = 1'b1;
            end
            S_T7_ST: begin
                o.write = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Next-state logic, plus retire and illegal-opcode events.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_bad_op     = 1'b0;
        case (r_state)
            S_HALT:   if (Start) w_next_state = S_T0;
            S_T0:     w_next_state = S_T1;
            S_T1:     if (bus.Mem_ready) w_next_state = S_T2;
            S_T2:     w_next_state = S_T3;
            S_T3: begin
                case (w_opcode)
                    OP_LD, OP_LDI, OP_ST: w_next_state = S_T4;
                    OP_HALT:              w_next_state = S_HALT;
                    default: begin
                        w_bad_op     = 1'b1;
                        w_next_state = Stop ? S_HALT : S_T0;
                    end
                endcase
            end
            S_T4: begin
                // Opcode legality was settled in T3; anything other than
                // ldi/st here completes as ld.
                case (w_opcode)
                    OP_LDI:  w_next_state = S_T5_LDI;
                    OP_ST:   w_next_state = S_T5_ST;
                    default: w_next_state = S_T5_LD;
                endcase
            end
            S_T5_LD:  w_next_state = S_T6_LD;
            S_T5_ST:  w_next_state = S_T6_ST;
            S_T6_LD:  if (bus.Mem_ready) w_next_state = S_T7_LD;
            S_T6_ST:  w_next_state = S_T7_ST;
            S_T5_LDI, S_T7_LD: begin
                w_retire     = 1'b1;
                w_next_state = Stop ? S_HALT : S_T0;
            end
            S_T7_ST: begin
                if (bus.Mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = Stop ? S_HALT : S_T0;
                end
            end
            default:  w_next_state = S_HALT;
        endcase
    end

    // State register with strobes registered from the next-state decode.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= S_HALT;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            r_out   <= f_decode(w_next_state);
        end
    end

    // Retired-instruction counter and sticky illegal-opcode flag.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) r_count <= r_count + 16'd1;
            if (w_bad_op) r_illegal <= 1'b1;
        end
    end

    assign Run         = r_out.run;
    assign Illegal     = r_illegal;
    assign Instr_count = r_count;

    assign bus.PCout   = r_out.pcout;
    assign bus.Zlowout = r_out.zlowout;
    assign bus.MDRout  = r_out.mdrout;
    assign bus.MARin   = r_out.marin;
    assign bus.Zin     = r_out.zin;
    assign bus.PCin    = r_out.pcin;
    assign bus.MDRin   = r_out.mdrin;
    assign bus.IRin    = r_out.irin;
    assign bus.Yin     = r_out.yin;
    assign bus.IncPC   = r_out.incpc;
    assign bus.Read    = r_out.read;
    assign bus.ReadEn  = r_out.readen;
    assign bus.Write   = r_out.write;
    assign bus.Gra     = r_out.gra;
    assign bus.Grb     = r_out.grb;
    assign bus.Rin     = r_out.rin;
    assign bus.Rout    = r_out.rout;
    assign bus.BAout   = r_out.baout;
    assign bus.Cout    = r_out.cout;
    assign bus.ADD     = r_out.add;

endmodule

// File: tb/tb_mem_control_unit.sv
// Directed, table-driven bench for mem_control_unit.
module tb_mem_control_unit;

    logic        clk;
    logic        clear;
    logic        start;
    logic        stop;
    logic        run;
    logic        illegal;
    logic [15:0] instr_count;

    mem_control_unit_if bus ();

    mem_control_unit dut (
        .Clock       (clk),
        .Clear       (clear),
        .Start       (start),
        .Stop        (stop),
        .Run         (run),
        .Illegal     (illegal),
        .Instr_count (instr_count),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [20:0] M_RUN    = 21'd1 << 20;
    localparam logic [20:0] M_PCOUT  = 21'd1 << 19;
    localparam logic [20:0] M_ZLO    = 21'd1 << 18;
    localparam logic [20:0] M_MDROUT = 21'd1 << 17;
    localparam logic [20:0] M_MARIN  = 21'd1 << 16;
    localparam logic [20:0] M_ZIN    = 21'd1 << 15;
    localparam logic [20:0] M_PCIN   = 21'd1 << 14;
    localparam logic [20:0] M_MDRIN  = 21'd1 << 13;
    localparam logic [20:0] M_IRIN   = 21'd1 << 12;
    localparam logic [20:0] M_YIN    = 21'd1 << 11;
    localparam logic [20:0] M_INCPC  = 21'd1 << 10;
    localparam logic [20:0] M_READ   = 21'd1 << 9;
    localparam logic [20:0] M_READEN = 21'd1 << 8;
    localparam logic [20:0] M_WRITE  = 21'd1 << 7;
    localparam logic [20:0] M_GRA    = 21'd1 << 6;
    localparam logic [20:0] M_GRB    = 21'd1 << 5;
    localparam logic [20:0] M_RIN    = 21'd1 << 4;
    localparam logic [20:0] M_ROUT   = 21'd1 << 3;
    localparam logic [20:0] M_BAOUT  = 21'd1 << 2;
    localparam logic [20:0] M_COUT   = 21'd1 << 1;
    localparam logic [20:0] M_ADD    = 21'd1 << 0;

    localparam logic [20:0] E_HALT   = 21'd0;
    localparam logic [20:0] E_T0     = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [20:0] E_T1     = M_RUN | M_ZLO | M_PCIN | M_READ | M_READEN | M_MDRIN;
    localparam logic [20:0] E_T2     = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [20:0] E_T3     = M_RUN | M_GRB | M_BAOUT | M_YIN;
    localparam logic [20:0] E_T4     = M_RUN | M_COUT | M_ADD | M_ZIN;
    localparam logic [20:0] E_T5M    = M_RUN | M_ZLO | M_MARIN;
    localparam logic [20:0] E_T5LDI  = M_RUN | M_ZLO | M_GRA | M_RIN;
    localparam logic [20:0] E_T6LD   = M_RUN | M_READ | M_READEN | M_MDRIN;
    localparam logic [20:0] E_T7LD   = M_RUN | M_MDROUT | M_GRA | M_RIN;
    localparam logic [20:0] E_T6ST   = M_RUN | M_GRA | M_ROUT | M_MDRIN;
    localparam logic [20:0] E_T7ST   = M_RUN | M_WRITE;

    localparam logic [31:0] IR_LD  = 32'h0080_0000;
    localparam logic [31:0] IR_LDI = 32'h0880_0000;
    localparam logic [31:0] IR_ST  = 32'h1080_0000;
    localparam logic [31:0] IR_ILL = 32'hF800_0000;
    localparam logic [31:0] IR_HLT = 32'hD800_0000;

    typedef struct {
        logic        start;
        logic        stop;
        logic        rdy;
        logic [31:0] ir;
        logic [20:0] exp_strobes;
        logic [15:0] exp_count;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [20:0] observed();
        return {run, bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin,
                bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read,
                bus.ReadEn, bus.Write, bus.Gra, bus.Grb, bus.Rin, bus.Rout,
                bus.BAout, bus.Cout, bus.ADD};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic rdy,
                       input logic [31:0] ir, input logic [20:0] e,
                       input logic [15:0] c, input logic il);
        vec_t v;
        v.start = st; v.stop = sp; v.rdy = rdy; v.ir = ir;
        v.exp_strobes = e; v.exp_count = c; v.exp_illegal = il;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row: outputs expected in this cycle, inputs driven for its edge.
        add(0, 0, 1, 32'h0, E_HALT,   16'd0, 0);
        add(1, 0, 1, 32'h0, E_HALT,   16'd0, 0);
        add(0, 0, 1, IR_LD, E_T0,     16'd0, 0);
        add(0, 0, 1, IR_LD, E_T1,     16'd0, 0);
        add(0, 0, 1, IR_LD, E_T2,     16'd0, 0);
        add(0, 0, 1, IR_LD, E_T3,     16'd0, 0);
        add(0, 0, 1, IR_LD, E_T4,     16'd0, 0);
        add(0, 0, 1, IR_ST, E_T5M,    16'd0, 0);
        add(0, 0, 0, IR_ST, E_T6LD,   16'd0, 0);
        add(0, 0, 1, IR_ST, E_T6LD,   16'd0, 0);
        add(0, 0, 1, IR_ST, E_T7LD,   16'd0, 0);
        add(0, 0, 0, IR_ST, E_T0,     16'd1, 0);
        add(0, 0, 1, IR_ST, E_T1,     16'd1, 0);
        add(0, 0, 1, IR_ST, E_T2,     16'd1, 0);
        add(0, 0, 1, IR_ST, E_T3,     16'd1, 0);
        add(0, 0, 1, IR_ST, E_T4,     16'd1, 0);
        add(0, 0, 1, IR_ST, E_T5M,    16'd1, 0);
        add(0, 0, 0, IR_ST, E_T6ST,   16'd1, 0);
        add(0, 0, 0, IR_ST, E_T7ST,   16'd1, 0);
        add(0, 0, 0, IR_ST, E_T7ST,   16'd1, 0);
        add(0, 0, 0, IR_ST, E_T7ST,   16'd1, 0);
        add(0, 0, 1, IR_ST, E_T7ST,   16'd1, 0);
        add(0, 0, 0, IR_LDI, E_T0,    16'd2, 0);
        add(0, 0, 0, IR_LDI, E_T1,    16'd2, 0);
        add(0, 0, 1, IR_LDI, E_T1,    16'd2, 0);
        add(0, 0, 1, IR_LDI, E_T2,    16'd2, 0);
        add(0, 0, 1, IR_LDI, E_T3,    16'd2, 0);
        add(0, 0, 1, IR_LDI, E_T4,    16'd2, 0);
        add(0, 1, 1, IR_LDI, E_T5LDI, 16'd2, 0);
        add(0, 0, 1, IR_LDI, E_HALT,  16'd3, 0);
        add(1, 0, 1, IR_ILL, E_HALT,  16'd3, 0);
        add(1, 1, 1, IR_ILL, E_T0,    16'd3, 0);
        add(0, 0, 1, IR_ILL, E_T1,    16'd3, 0);
        add(0, 0, 1, IR_ILL, E_T2,    16'd3, 0);
        add(0, 0, 1, IR_ILL, E_T3,    16'd3, 0);
        add(0, 0, 1, IR_HLT, E_T0,    16'd3, 1);
        add(0, 0, 1, IR_HLT, E_T1,    16'd3, 1);
        add(0, 0, 1, IR_HLT, E_T2,    16'd3, 1);
        add(0, 0, 1, IR_HLT, E_T3,    16'd3, 1);
        add(1, 0, 1, IR_ILL, E_HALT,  16'd3, 1);
        add(0, 0, 1, IR_ILL, E_T0,    16'd3, 1);
        add(0, 0, 1, IR_ILL, E_T1,    16'd3, 1);
        add(0, 0, 1, IR_ILL, E_T2,    16'd3, 1);
        add(0, 1, 1, IR_ILL, E_T3,    16'd3, 1);
        add(0, 0, 1, IR_ILL, E_HALT,  16'd3, 1);

        clear = 1'b0; start = 1'b0; stop = 1'b0;
        bus.Mem_ready = 1'b1; bus.IR = 32'h0;

        repeat (2) @(negedge clk);
        chk("reset strobes", 32'(observed()), 32'(E_HALT));
        chk("reset count",   32'(instr_count), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        clear = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("row%0d strobes", i), 32'(observed()), 32'(vecs[i].exp_strobes));
            chk($sformatf("row%0d count", i),   32'(instr_count), 32'(vecs[i].exp_count));
            chk($sformatf("row%0d illegal", i), 32'(illegal), 32'(vecs[i].exp_illegal));
            start         = vecs[i].start;
            stop          = vecs[i].stop;
            bus.Mem_ready = vecs[i].rdy;
            bus.IR        = vecs[i].ir;
        end

        // Clear mid-instruction while ld sits in T6 waiting on memory.
        @(negedge clk);
        start = 1'b1; bus.IR = IR_LD; bus.Mem_ready = 1'b1;
        @(negedge clk);
        chk("clr T0", 32'(observed()), 32'(E_T0));
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("clr T5", 32'(observed()), 32'(E_T5M));
        bus.Mem_ready = 1'b0;
        @(negedge clk);
        chk("clr T6 hold", 32'(observed()), 32'(E_T6LD));
        #2 clear = 1'b0;
        #1;
        chk("clr async strobes", 32'(observed()), 32'(E_HALT));
        chk("clr async count",   32'(instr_count), 32'd0);
        chk("clr async illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        clear = 1'b1; bus.Mem_ready = 1'b1;
        @(negedge clk);
        chk("clr stays halt", 32'(observed()), 32'(E_HALT));

        // Back-to-back ldi: 6 cycles each, no bubble between instructions.
        start = 1'b1; bus.IR = IR_LDI;
        @(negedge clk);
        start = 1'b0;
        chk("b2b first T0", 32'(observed()), 32'(E_T0));
        for (int k = 1; k <= 10; k++) begin
            repeat (6) @(negedge clk);
            chk($sformatf("b2b T0 #%0d", k), 32'(observed()), 32'(E_T0));
            chk($sformatf("b2b count #%0d", k), 32'(instr_count), 32'(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
